// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the LEGv8 single-issue core. Holds the program counter,
// issues one instruction-memory request at a time over a req/ack handshake
// and registers the returned word into a one-entry instruction slot.
//
// Parameters:
//   ADDR_W   - PC / instruction memory address width
//   PC_RESET - PC value loaded by reset (4-byte aligned)
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   imem_req      out  fetch request, held until imem_ack
//   imem_addr     out  fetch address (the PC register)
//   imem_ack      in   one-cycle response pulse, imem_rdata valid with it
//   imem_rdata    in   instruction word
//   stall         in   downstream cannot take the slot this cycle
//   branch_taken  in   one-cycle redirect pulse from execute
//   branch_target in   redirect address, low two bits ignored
//   instr         out  slot instruction word
//   instr_pc      out  address the slot word was fetched from
//   opcode        out  instr[31:22], registered with instr
//   instr_valid   out  slot holds a live instruction
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [9:0]        opcode,
    output logic              instr_valid
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_REQ  = 1'b1;

    logic              r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_target;   // redirect waiting for the in-flight ack
    logic              r_squash;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [9:0]        r_opcode;
    logic              r_valid;

    logic [ADDR_W-1:0] w_target;
    logic              w_consume;

    // Masking keeps every target bit in use while forcing word alignment.
    assign w_target  = branch_target & ~ADDR_W'(3);
    assign w_consume = r_valid & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= PC_RESET;
            r_target   <= PC_RESET;
            r_squash   <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_opcode   <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (w_consume) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (branch_taken) begin
                        r_pc    <= w_target;
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                    end else if (!r_valid || !stall) begin
                        // Only request when the slot is guaranteed empty by
                        // the time the ack returns, so no skid buffer exists.
                        r_state <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (branch_taken) begin
                        r_valid <= 1'b0;
                        if (imem_ack) begin
                            // Response retires in the same edge: redirect directly.
                            r_pc     <= w_target;
                            r_squash <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            // imem_addr must stay stable until the ack, so park
                            // the target; a later branch overwrites it.
                            r_target <= w_target;
                            r_squash <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        r_state <= S_IDLE;
                        if (r_squash) begin
                            r_pc     <= r_target;
                            r_squash <= 1'b0;
                        end else begin
                            r_instr    <= imem_rdata;
                            r_opcode   <= imem_rdata[31:22];
                            r_instr_pc <= r_pc;
                            r_valid    <= 1'b1;
                            r_pc       <= r_pc + ADDR_W'(4);
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_opcode;
    assign instr_valid = r_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. Two instances: u_dut (PC_RESET=0)
// with a variable-latency memory responder, and u_wrap (PC_RESET=2^64-4)
// with a fixed one-cycle responder to exercise PC wrap-around.
// Memory word for address a is {a[11:2], a[23:2]} so opcode = a[11:2].
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [9:0]  opcode;
    logic        instr_valid;

    logic        w2_req;
    logic [63:0] w2_addr;
    logic        w2_ack;
    logic [31:0] w2_rdata;
    logic [31:0] w2_instr;
    logic [63:0] w2_instr_pc;
    logic [9:0]  w2_opcode;
    logic        w2_valid;

    int mem_lat;
    int n_checks;
    int n_errors;

    instruction_fetch #(.ADDR_W(64), .PC_RESET(64'h0)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .opcode        (opcode),
        .instr_valid   (instr_valid)
    );

    instruction_fetch #(.ADDR_W(64), .PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (w2_req),
        .imem_addr     (w2_addr),
        .imem_ack      (w2_ack),
        .imem_rdata    (w2_rdata),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (64'h0),
        .instr         (w2_instr),
        .instr_pc      (w2_instr_pc),
        .opcode        (w2_opcode),
        .instr_valid   (w2_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[11:2], a[23:2]};
    endfunction

    // Memory responder: ack arrives mem_lat cycles after imem_req rises.
    initial begin
        int wc;
        wc         = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset || !imem_req) begin
                imem_ack = 1'b0;
                wc       = 0;
            end else if (wc == mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wc         = 0;
            end else begin
                imem_ack = 1'b0;
                wc++;
            end
        end
    end

    // Fixed one-cycle-latency responder for the wrap instance.
    initial begin
        int wc2;
        wc2      = 0;
        w2_ack   = 1'b0;
        w2_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset || !w2_req) begin
                w2_ack = 1'b0;
                wc2    = 0;
            end else if (wc2 == 1) begin
                w2_ack   = 1'b1;
                w2_rdata = mem_word(w2_addr);
                wc2      = 0;
            end else begin
                w2_ack = 1'b0;
                wc2++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        mem_lat       = 1;
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;

        // ---- reset state ----
        repeat (3) step();
        check("rst_req",     64'(imem_req),    64'h0);
        check("rst_addr",    imem_addr,        64'h0);
        check("rst_valid",   64'(instr_valid), 64'h0);
        check("rst_instr",   64'(instr),       64'h0);
        check("rst_ipc",     instr_pc,         64'h0);
        check("rst_opcode",  64'(opcode),      64'h0);
        check("rst_w_addr",  w2_addr,          64'hFFFF_FFFF_FFFF_FFFC);

        // Release mid-cycle; request appears in the second cycle.
        #2 reset = 1'b0;
        #1;
        check("rel_req0", 64'(imem_req), 64'h0);
        step();
        check("first_req",   64'(imem_req), 64'h1);
        check("first_addr",  imem_addr,     64'h0);
        check("w_first_addr", w2_addr,      64'hFFFF_FFFF_FFFF_FFFC);

        // ---- sequential fetch, L=1 ----
        step();
        check("ack0_valid", 64'(instr_valid), 64'h0);
        step();
        check("s0_valid",  64'(instr_valid), 64'h1);
        check("s0_pc",     instr_pc,         64'h0);
        check("s0_instr",  64'(instr),       64'h0);
        check("s0_req",    64'(imem_req),    64'h0);
        check("w_s0_pc",   w2_instr_pc,      64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("s1_req",    64'(imem_req),    64'h1);
        check("s1_addr",   imem_addr,        64'h4);
        check("s1_vclr",   64'(instr_valid), 64'h0);
        check("w_wrap",    w2_addr,          64'h0);
        step();
        step();
        check("s1_valid",  64'(instr_valid), 64'h1);
        check("s1_pc",     instr_pc,         64'h4);
        check("s1_instr",  64'(instr),       64'h0040_0001);
        check("s1_opcode", 64'(opcode),      64'h1);

        // ---- stall holds the slot ----
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stl_valid", 64'(instr_valid), 64'h1);
            check("stl_instr", 64'(instr),       64'h0040_0001);
            check("stl_req",   64'(imem_req),    64'h0);
        end
        stall   = 1'b0;
        mem_lat = 4;
        step();
        check("rel_req",   64'(imem_req),    64'h1);
        check("rel_addr",  imem_addr,        64'h8);
        check("rel_vclr",  64'(instr_valid), 64'h0);

        // ---- squash: branch while request for 0x8 outstanding, L=4 ----
        branch_taken  = 1'b1;
        branch_target = 64'h103;
        step();
        branch_taken  = 1'b0;
        branch_target = '0;
        for (int i = 0; i < 4; i++) begin
            check("sq_addr",  imem_addr,     64'h8);
            check("sq_req",   64'(imem_req), 64'h1);
            step();
        end
        check("sq_idle_req", 64'(imem_req),    64'h0);
        check("sq_drop",     64'(instr_valid), 64'h0);
        step();
        check("sq_new_req",  64'(imem_req), 64'h1);
        check("sq_new_addr", imem_addr,     64'h100);
        for (int i = 0; i < 4; i++) begin
            step();
            check("sq_wait_v", 64'(instr_valid), 64'h0);
        end
        step();
        check("sq_valid",  64'(instr_valid), 64'h1);
        check("sq_pc",     instr_pc,         64'h100);
        check("sq_opcode", 64'(opcode),      64'h040);
        check("sq_instr",  64'(instr),       64'h1000_0040);
        step();
        check("nx_req",  64'(imem_req), 64'h1);
        check("nx_addr", imem_addr,     64'h104);

        // ---- async reset mid-request ----
        #2 reset = 1'b1;
        #1;
        check("ar_req",    64'(imem_req),    64'h0);
        check("ar_addr",   imem_addr,        64'h0);
        check("ar_valid",  64'(instr_valid), 64'h0);
        check("ar_instr",  64'(instr),       64'h0);
        check("ar_ipc",    instr_pc,         64'h0);
        check("ar_opcode", 64'(opcode),      64'h0);
        mem_lat = 1;
        step();
        step();
        #2 reset = 1'b0;
        step();
        check("r2_req",  64'(imem_req), 64'h1);
        check("r2_addr", imem_addr,     64'h0);

        // ---- same-cycle branch and ack for 0x8 ----
        repeat (5) step();
        check("sc_pre_pc",  instr_pc,         64'h4);
        step();
        check("sc_req8",    imem_addr,        64'h8);
        step();
        branch_taken  = 1'b1;
        branch_target = 64'h40;
        step();
        branch_taken  = 1'b0;
        branch_target = '0;
        check("sc_req",   64'(imem_req),    64'h0);
        check("sc_valid", 64'(instr_valid), 64'h0);
        step();
        check("sc_nreq",  64'(imem_req), 64'h1);
        check("sc_naddr", imem_addr,     64'h40);
        step();
        step();
        check("sc_valid2", 64'(instr_valid), 64'h1);
        check("sc_pc",     instr_pc,         64'h40);
        check("sc_instr",  64'(instr),       64'h0400_0010);
        check("sc_opcode", 64'(opcode),      64'h010);

        // ---- branch in IDLE flushes a stalled slot ----
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 64'h201;
        step();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        check("fl_valid", 64'(instr_valid), 64'h0);
        check("fl_req",   64'(imem_req),    64'h1);
        check("fl_addr",  imem_addr,        64'h200);
        step();
        step();
        check("fl_tvalid", 64'(instr_valid), 64'h1);
        check("fl_pc",     instr_pc,         64'h200);
        check("fl_instr",  64'(instr),       64'h2000_0080);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
